sram_32k_access_ctrl: RTL

SRAM_32K_ACCESS_CTRL -- requirements
Module: sram_32k_access_ctrl

---
 rtl/sram_32k_access_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sram_32k_access_ctrl.sv
// rtl/sram_32k_access_ctrl.sv - request/response controller for the 8192 x 32 SRAM macro
// Registered SRAM cycles, 2-entry read response FIFO with credit, and a standby FSM.
module sram_32k_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [12:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  input  logic        stby_req,
  output logic        stby_ack,
  output logic        gate_mem,
  output logic        sram_n_cs,
  output logic        sram_n_we,
  output logic        sram_n_oe,
  output logic [31:0] sram_mask,
  output logic [12:0] sram_ad,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  typedef enum logic [1:0] {RUN, DRAIN, STBY, WAKE} state_t;

  state_t      state;
  logic        rd_p1;
  logic        rd_p2;
  logic [31:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        pop;
  logic        accept;
  logic        rd_credit;
  logic [2:0]  outstanding;
  logic [31:0] wr_mask;

  // rd_p1: SRAM read cycle on the pins; rd_p2: sram_dout valid, captured at the next edge.
  assign rsp_valid   = (fifo_cnt != 2'd0);
  assign rsp_rdata   = fifo_mem[rd_ptr];
  assign pop         = rsp_valid & rsp_ready;
  assign outstanding = {2'b00, rd_p1} + {2'b00, rd_p2} + {1'b0, fifo_cnt} - {2'b00, pop};
  assign rd_credit   = (outstanding < 3'd2);
  assign req_ready   = (state == RUN) && !stby_req && (req_we || rd_credit);
  assign accept      = req_valid & req_ready;

  always_comb begin
    wr_mask = '1;
    for (int i = 0; i < 4; i++) begin
      wr_mask[8*i +: 8] = {8{~req_be[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (rd_p2) begin
        fifo_mem[wr_ptr] <= sram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_p2} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stby_ack  <= 1'b0;
      gate_mem  <= 1'b0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      sram_n_cs <= 1'b1;
      sram_n_we <= 1'b1;
      sram_n_oe <= 1'b1;
      sram_mask <= '1;
      sram_ad   <= '0;
      sram_din  <= '0;
    end else begin
      rd_p1     <= accept & ~req_we;
      rd_p2     <= rd_p1;
      sram_n_cs <= ~accept;
      sram_n_we <= ~(accept & req_we);
      sram_n_oe <= ~(accept & ~req_we);
      sram_ad   <= accept ? req_addr : '0;
      sram_din  <= (accept & req_we) ? req_wdata : '0;
      sram_mask <= (accept & req_we) ? wr_mask : '1;
      case (state)
        RUN: begin
          if (stby_req) state <= DRAIN;
        end
        DRAIN: begin
          // A dropped stby_req still finishes the drain, but returns to RUN without gating.
          if (!rd_p1 && !rd_p2 && sram_n_cs) begin
            if (stby_req) begin
              state    <= STBY;
              stby_ack <= 1'b1;
              gate_mem <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        STBY: begin
          if (!stby_req) begin
            state    <= WAKE;
            stby_ack <= 1'b0;
            gate_mem <= 1'b0;
          end
        end
        WAKE: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
